// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with power-of-two depth, programmable
// almost-full/almost-empty thresholds, exact fill level, sticky error flags
// and selectable standard (registered) or first-word-fall-through read.
//
// Ports:
//   clk          clock, all state on rising edge
//   rstn         asynchronous reset, active-high
//   i_wren       write request
//   i_wrdata     write data
//   i_rden       read request (FWFT: pop the presented head word)
//   i_clr_err    synchronous clear of o_overflow/o_underflow
//   o_rddata     read data
//   o_rdvalid    standard: 1-cycle pulse with o_rddata; FWFT: head word present
//   o_full       level == DEPTH
//   o_empty      level == 0
//   o_alm_full   level >= DEPTH-ALM_FULL_TH
//   o_alm_empty  level <= ALM_EMPTY_TH
//   o_level      stored word count, 0..DEPTH
//   o_overflow   sticky: write attempted while full
//   o_underflow  sticky: read attempted while empty
module sync_fifo_param #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ALM_FULL_TH  = 4,
  parameter int unsigned ALM_EMPTY_TH = 2,
  parameter bit          FWFT         = 1'b0,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned LW          = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [LW-1:0]     o_level,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [LW-1:0] DepthLvl   = LW'(DEPTH);
  localparam logic [LW-1:0] AlmFullLvl = LW'(DEPTH - ALM_FULL_TH);
  localparam logic [LW-1:0] AlmEmpLvl  = LW'(ALM_EMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, alm_full_q, alm_empty_q;
  logic          overflow_q, underflow_q;
  logic          overflow_d, underflow_d;
  logic          wr_ok, rd_ok;

  // Acceptance uses the registered flags, so a read on a full FIFO does not
  // make room for a write in the same cycle.
  assign wr_ok = i_wren & ~full_q;
  assign rd_ok = i_rden & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Set takes priority over a same-cycle clear.
  assign overflow_d  = (overflow_q & ~i_clr_err) | (i_wren & full_q);
  assign underflow_d = (underflow_q & ~i_clr_err) | (i_rden & empty_q);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alm_full_q  <= 1'b0;
      alm_empty_q <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      level_q     <= level_d;
      // Flags derive from the next level so they are exact right after the edge.
      full_q      <= (level_d == DepthLvl);
      empty_q     <= (level_d == '0);
      alm_full_q  <= (level_d >= AlmFullLvl);
      alm_empty_q <= (level_d <= AlmEmpLvl);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= i_wrdata;
  end

  if (FWFT) begin : g_fwft
    assign o_rddata  = mem[rptr_q];
    assign o_rdvalid = ~empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] rddata_q;
    logic              rdvalid_q;

    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
        rddata_q  <= '0;
        rdvalid_q <= 1'b0;
      end else begin
        rdvalid_q <= rd_ok;
        if (rd_ok) rddata_q <= mem[rptr_q];
      end
    end

    assign o_rddata  = rddata_q;
    assign o_rdvalid = rdvalid_q;
  end

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_alm_full  = alm_full_q;
  assign o_alm_empty = alm_empty_q;
  assign o_level     = level_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT instance share the
// same stimulus; a queue model is compared every cycle, and directed steps add
// hand-computed literal expectations.
module tb_sync_fifo_param;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int AF = 4;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wren = 1'b0, rden = 1'b0, clr = 1'b0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] s_dat, f_dat;
  logic s_vld, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_vld, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_lvl, f_lvl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(AF), .ALM_EMPTY_TH(AE),
                    .FWFT(1'b0)) u_std (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wdata), .i_rden(rden),
    .i_clr_err(clr), .o_rddata(s_dat), .o_rdvalid(s_vld), .o_full(s_full),
    .o_empty(s_empty), .o_alm_full(s_af), .o_alm_empty(s_ae), .o_level(s_lvl),
    .o_overflow(s_ovf), .o_underflow(s_unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(AF), .ALM_EMPTY_TH(AE),
                    .FWFT(1'b1)) u_fwft (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wdata), .i_rden(rden),
    .i_clr_err(clr), .o_rddata(f_dat), .o_rdvalid(f_vld), .o_full(f_full),
    .o_empty(f_empty), .o_alm_full(f_af), .o_alm_empty(f_ae), .o_level(f_lvl),
    .o_overflow(f_ovf), .o_underflow(f_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words plus the observable side effects.
  logic [DW-1:0] mq[$];
  logic m_ovf = 1'b0, m_unf = 1'b0, m_vld = 1'b0;
  logic [DW-1:0] m_dat = '0;

  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
      m_vld <= 1'b0;
      m_dat <= '0;
    end else begin
      automatic int n = mq.size();
      automatic bit do_rd = rden && (n != 0);
      automatic bit do_wr = wren && (n != DEPTH);
      m_vld <= do_rd;
      if (do_rd) m_dat <= mq.pop_front();
      if (do_wr) mq.push_back(wdata);
      m_ovf <= (wren && n == DEPTH) || (m_ovf && !clr);
      m_unf <= (rden && n == 0) || (m_unf && !clr);
    end
  end

  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("std_level", 32'(s_lvl), 32'(n));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_full", 32'(s_full), 32'(n == DEPTH));
    chk("std_alm_full", 32'(s_af), 32'(n >= DEPTH - AF));
    chk("std_alm_empty", 32'(s_ae), 32'(n <= AE));
    chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("std_unf", 32'(s_unf), 32'(m_unf));
    chk("std_rdvalid", 32'(s_vld), 32'(m_vld));
    chk("std_rddata", 32'(s_dat), 32'(m_dat));
    chk("fwft_level", 32'(f_lvl), 32'(n));
    chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("fwft_unf", 32'(f_unf), 32'(m_unf));
    chk("fwft_rdvalid", 32'(f_vld), 32'(n != 0));
    if (n != 0) chk("fwft_rddata", 32'(f_dat), 32'(mq[0]));
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wren = w;
    wdata = d;
    rden = r;
    clr = c;
    @(posedge clk);
    #1;
    wren = 1'b0;
    rden = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #2 rstn = 1'b1;
    #20 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_alm_empty", 32'(s_ae), 32'd1);
    chk("rst_level", 32'(s_lvl), 32'd0);

    // Fill with 0x1..0x10 and pin the threshold crossings.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 2) chk("ae_at_2", 32'(s_ae), 32'd1);
      if (i == 3) chk("ae_at_3", 32'(s_ae), 32'd0);
      if (i == 11) chk("af_at_11", 32'(s_af), 32'd0);
      if (i == 12) chk("af_at_12", 32'(s_af), 32'd1);
      if (i == 15) chk("full_at_15", 32'(s_full), 32'd0);
      if (i == 16) chk("full_at_16", 32'(s_full), 32'd1);
    end

    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_level", 32'(s_lvl), 32'd16);

    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_vld", 32'(s_vld), 32'd1);
      chk("drain_data", 32'(s_dat), 32'(i));
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("vld_pulse_end", 32'(s_vld), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(s_ovf), 32'd0);

    // Underflow on empty, then simultaneous write+read on empty.
    step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_vld", 32'(s_vld), 32'd0);
    chk("unf_set", 32'(s_unf), 32'd1);
    chk("unf_level", 32'(s_lvl), 32'd0);
    step(1'b1, 16'h0055, 1'b1, 1'b0);
    chk("wr_rd_empty_level", 32'(s_lvl), 32'd1);
    chk("wr_rd_empty_unf", 32'(s_unf), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("read_55", 32'(s_dat), 32'h55);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("set_beats_clr", 32'(s_unf), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("unf_clr", 32'(s_unf), 32'd0);

    // Streaming across pointer wrap at constant level 8.
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, DW'(16'h200 + k), 1'b1, 1'b0);
      chk("stream_level", 32'(s_lvl), 32'd8);
      chk("stream_data", 32'(s_dat), (k < 8) ? 32'(16'h100 + k) : 32'(16'h200 + k - 8));
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("stream_tail", 32'(s_dat), 32'(16'h200 + 32 + k));
    end
    chk("stream_empty", 32'(s_empty), 32'd1);

    // FWFT: head appears one cycle after its write, pop empties.
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    chk("fwft_head", 32'(f_dat), 32'hA5);
    chk("fwft_vld", 32'(f_vld), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Async reset mid-burst at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h300 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(s_lvl), 32'd5);
    #2 rstn = 1'b1;
    #1;
    chk("arst_level", 32'(s_lvl), 32'd0);
    chk("arst_empty", 32'(s_empty), 32'd1);
    chk("arst_ae", 32'(s_ae), 32'd1);
    chk("arst_af", 32'(s_af), 32'd0);
    chk("arst_data", 32'(s_dat), 32'd0);
    chk("arst_fwft_vld", 32'(f_vld), 32'd0);
    chk("arst_fwft_level", 32'(f_lvl), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_vld", 32'(s_vld), 32'd0);
    chk("post_rst_fvld", 32'(f_vld), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_rd_vld", 32'(s_vld), 32'd0);
    step(1'b1, 16'h0077, 1'b0, 1'b1);
    chk("post_rst_fhead", 32'(f_dat), 32'h77);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_read", 32'(s_dat), 32'h77);
    chk("post_rst_rvld", 32'(s_vld), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with configurable width, power-of-two depth, programmable almost-full/almost-empty thresholds, an exact fill-level output, and selectable standard or first-word-fall-through (FWFT) read mode. It adds sticky overflow/underflow error flags. It is the general-purpose buffering element between producer and consumer datapaths in the same clock domain, and replaces fixed 128x1024 FIFO instances.

## Interface
- DATA_W, 128, data word width in bits (>=1)
- DEPTH, 1024, number of entries; power of two, >=4
- ALM_FULL_TH, 4, o_alm_full asserts when free entries <= ALM_FULL_TH (1..DEPTH-1)
- ALM_EMPTY_TH, 2, o_alm_empty asserts when level <= ALM_EMPTY_TH (1..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- Derived: AW = log2(DEPTH); level width LW = AW+1
- Reset and clock: reset rstn, asynchronous, active-high; clock clk.
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous reset, active-high
- i_wren  in  1  write request
- i_wrdata  in  DATA_W  write data
- i_rden  in  1  read request (FWFT: pop/acknowledge head word)
- i_clr_err  in  1  synchronous clear of o_overflow/o_underflow
- o_rddata  out  DATA_W  read data
- o_rdvalid  out  1  standard: 1-cycle pulse, o_rddata valid; FWFT: head word present
- o_full  out  1  level == DEPTH
- o_empty  out  1  level == 0
- o_alm_full  out  1  level >= DEPTH-ALM_FULL_TH
- o_alm_empty  out  1  level <= ALM_EMPTY_TH
- o_level  out  LW  current number of stored words, 0..DEPTH
- o_overflow  out  1  sticky: write attempted while full
- o_underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_W array, AW-bit write/read pointers that wrap modulo DEPTH naturally; LW-bit level register. Memory contents are not reset.
- Write accepted (wr_ok) iff i_wren && !o_full. wr_ok stores i_wrdata at wptr and increments wptr.
- Read accepted (rd_ok) iff i_rden && !o_empty. rd_ok increments rptr.
- Acceptance uses registered flags at the start of the cycle. A read on a full FIFO does not free space for a same-cycle write.
- Level update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- Simultaneous write+read: on empty, only the write is accepted and the read sets o_underflow. On full, only the read is accepted and the write sets o_overflow. Otherwise both are accepted.
- i_wren && o_full sets o_overflow. i_rden && o_empty sets o_underflow. Both flags hold until i_clr_err or reset. If clear and set occur in the same cycle, set wins.
- All status flags are registered and computed from next-level, so they are exact in the cycle after the causing edge. o_level equals the level register.
- Standard mode (FWFT=0): rd_ok registers mem[rptr] into o_rddata and pulses o_rdvalid for one cycle. o_rddata otherwise holds its last value.
- FWFT mode (FWFT=1): o_rddata = mem[rptr] combinationally and o_rdvalid = !o_empty. i_rden consumes the presented word.
- Reset: pointers 0, o_level 0, o_empty 1, o_alm_empty 1, o_full 0, o_alm_full 0, o_rdvalid 0, o_rddata 0, o_overflow 0, o_underflow 0. Reset asserted mid-operation discards all contents immediately.

## Timing
- Write at edge N: o_level, o_empty and all flags reflect it after edge N. The word is readable (rd_ok possible) from cycle N+1.
- Standard read latency is 1 cycle: i_rden sampled at edge N, o_rddata/o_rdvalid valid after edge N.
- FWFT: head word visible in the cycle after its write into an empty FIFO, i.e. 1 cycle write-to-output.
- Sustained throughput is 1 write and 1 read per cycle when 0 < level < DEPTH.
- Pointer wrap DEPTH-1 -> 0 has no bubble.

## Test plan
- Reset/fill (DEPTH=16, AF=4, AE=2): after reset o_empty=1, o_alm_empty=1, o_level=0. Write 0x1..0x10 one per cycle -> o_alm_empty drops when level=3, o_alm_full rises when level=12, o_full=1 when level=16.
- Overflow: with the FIFO full, write 0xDEAD -> not stored, o_overflow=1, level stays 16. Read all 16 -> data 0x1..0x10 in order, 1-cycle o_rdvalid each. Pulse i_clr_err -> o_overflow=0.
- Underflow: with the FIFO empty, i_rden=1 -> o_rdvalid=0, o_underflow=1, level stays 0. Simultaneous wr+rd on empty -> level=1, o_underflow=1.
- Wrap-around streaming: hold level=8 and do 40 cycles of simultaneous wr+rd -> level constant at 8, output sequence matches input, no lost or duplicated words across pointer wrap.
- FWFT=1: write 0xA5 -> o_rddata=0xA5 with o_rdvalid=1 in the next cycle. i_rden -> o_empty=1 after the edge.
- Async reset asserted mid-burst at level=5 -> all outputs immediately at their reset values. After release, o_rdvalid stays 0 until new writes occur.
